// File: rtl/instr_seq_ctrl_if.sv
// Handshake/bus bundle for instr_seq_ctrl.
//   master : host/loader + exe_engine + instruction memory side
//   slave  : the sequencer itself
// Signals:
//   load_valid/load_data/load_last/load_ready : program loader beat handshake
//   start                                     : run the loaded program
//   op_valid/op_ready                         : opcode handshake with exe_engine
//   prog_pointer/write_data/data_to_write     : instruction memory control
//   prog_len/busy/done                        : status
interface instr_seq_ctrl_if #(
  parameter int AW = 4,
  parameter int OW = 26
) ();
  logic          load_valid;
  logic [OW-1:0] load_data;
  logic          load_last;
  logic          load_ready;
  logic          start;
  logic          op_valid;
  logic          op_ready;
  logic [AW-1:0] prog_pointer;
  logic          write_data;
  logic [OW-1:0] data_to_write;
  logic [AW-1:0] prog_len;
  logic          busy;
  logic          done;

  modport master (
    output load_valid, load_data, load_last, start, op_ready,
    input  load_ready, op_valid, prog_pointer, write_data, data_to_write,
           prog_len, busy, done
  );

  modport slave (
    input  load_valid, load_data, load_last, start, op_ready,
    output load_ready, op_valid, prog_pointer, write_data, data_to_write,
           prog_len, busy, done
  );
endinterface

// File: rtl/instr_seq_ctrl.sv
// Instruction sequencer: loads a program beat by beat into the instruction
// memory, then on start walks the program and hands each opcode (registered
// by the memory) to the exe_engine with a valid/ready handshake.
// Ports:
//   clk   : system clock
//   rst_n : synchronous active-low reset
//   bus   : instr_seq_ctrl_if.slave (loader, exe handshake, memory control,
//           status)
//
// state | meaning
// IDLE  | program closed; accepts load beats or start
// LOAD  | program being loaded, waiting for further beats
// ISSUE | memory address = pc, memory registers opcode at end of cycle
// VALID | opcode presented to exe_engine, waiting for op_ready
// DONE  | one-cycle done pulse, then back to IDLE
module instr_seq_ctrl #(
  parameter int DEPTH = 10,
  parameter int AW    = 4,
  parameter int OW    = 26
) (
  input logic             clk,
  input logic             rst_n,
  instr_seq_ctrl_if.slave bus
);

  typedef enum logic [2:0] {IDLE, LOAD, ISSUE, VALID, DONE} state_t;

  state_t        state;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] pc;
  logic [AW-1:0] prog_len_q;
  logic [AW-1:0] prog_pointer_q;
  logic [OW-1:0] data_to_write_q;
  logic          write_data_q;
  logic          op_valid_q;
  logic          done_q;
  logic          busy_q;

  logic          load_ready_c;
  logic          load_accept;
  logic          load_close;

  // Only combinational output; held low during reset so a beat cannot be
  // acknowledged while the controller is being cleared.
  assign load_ready_c = rst_n &&
                        ((state == IDLE) ||
                         ((state == LOAD) && (wr_ptr < AW'(DEPTH))));
  assign load_accept  = bus.load_valid && load_ready_c;
  // A full memory closes the program even without load_last.
  assign load_close   = bus.load_last || (wr_ptr == AW'(DEPTH - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state           <= IDLE;
      wr_ptr          <= '0;
      pc              <= '0;
      prog_len_q      <= '0;
      prog_pointer_q  <= '0;
      data_to_write_q <= '0;
      write_data_q    <= 1'b0;
      op_valid_q      <= 1'b0;
      done_q          <= 1'b0;
      busy_q          <= 1'b0;
    end else begin
      write_data_q <= 1'b0;
      done_q       <= 1'b0;
      // load_accept is only possible in IDLE/LOAD, so it also wins over start.
      if (load_accept) begin
        write_data_q    <= 1'b1;
        prog_pointer_q  <= wr_ptr;
        data_to_write_q <= bus.load_data;
        if (load_close) begin
          prog_len_q <= wr_ptr + AW'(1);
          wr_ptr     <= '0;
          state      <= IDLE;
          busy_q     <= 1'b0;
        end else begin
          wr_ptr <= wr_ptr + AW'(1);
          state  <= LOAD;
          busy_q <= 1'b1;
        end
      end else begin
        case (state)
          IDLE: begin
            if (bus.start && (prog_len_q != '0)) begin
              pc             <= '0;
              prog_pointer_q <= '0;
              state          <= ISSUE;
              busy_q         <= 1'b1;
            end
          end
          LOAD: begin
          end
          ISSUE: begin
            state      <= VALID;
            op_valid_q <= 1'b1;
          end
          VALID: begin
            // prog_pointer stays at pc so the memory keeps re-reading the
            // same opcode while the exe_engine back-pressures.
            if (bus.op_ready) begin
              op_valid_q <= 1'b0;
              if (pc == prog_len_q - AW'(1)) begin
                state  <= DONE;
                done_q <= 1'b1;
              end else begin
                pc             <= pc + AW'(1);
                prog_pointer_q <= pc + AW'(1);
                state          <= ISSUE;
              end
            end
          end
          DONE: begin
            state  <= IDLE;
            busy_q <= 1'b0;
            pc     <= '0;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

  assign bus.load_ready    = load_ready_c;
  assign bus.op_valid      = op_valid_q;
  assign bus.prog_pointer  = prog_pointer_q;
  assign bus.write_data    = write_data_q;
  assign bus.data_to_write = data_to_write_q;
  assign bus.prog_len      = prog_len_q;
  assign bus.busy          = busy_q;
  assign bus.done          = done_q;

endmodule
